// File: rtl/mem_to_axi_lite.sv
// Memory request (req/gnt/we/be/rvalid) to AXI4-Lite master bridge.
// One transaction in flight; the state machine is visible on dbg_state.
module mem_to_axi_lite #(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 64,
  parameter logic [2:0]  AXI_PROT   = 3'b000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_req_i,
  output logic                      mem_gnt_o,
  input  logic                      mem_we_i,
  input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
  input  logic [DATA_WIDTH-1:0]     mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   mem_be_i,
  output logic                      mem_rvalid_o,
  output logic [DATA_WIDTH-1:0]     mem_rdata_o,
  output logic                      mem_err_o,
  output logic [ADDR_WIDTH-1:0]     aw_addr_o,
  output logic [2:0]                aw_prot_o,
  output logic                      aw_valid_o,
  input  logic                      aw_ready_i,
  output logic [DATA_WIDTH-1:0]     w_data_o,
  output logic [DATA_WIDTH/8-1:0]   w_strb_o,
  output logic                      w_valid_o,
  input  logic                      w_ready_i,
  input  logic [1:0]                b_resp_i,
  input  logic                      b_valid_i,
  output logic                      b_ready_o,
  output logic [ADDR_WIDTH-1:0]     ar_addr_o,
  output logic [2:0]                ar_prot_o,
  output logic                      ar_valid_o,
  input  logic                      ar_ready_i,
  input  logic [DATA_WIDTH-1:0]     r_data_i,
  input  logic [1:0]                r_resp_i,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  output logic [2:0]                dbg_state
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WRITE  = 3'd1;
  localparam logic [2:0] WAIT_B = 3'd2;
  localparam logic [2:0] READ   = 3'd3;
  localparam logic [2:0] WAIT_R = 3'd4;

  // Handshake rule on every channel: a transfer happens on a rising clk
  // edge where valid && ready; a valid, once raised, holds its payload
  // stable until that edge and never depends combinationally on ready.

  logic [2:0]              state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic                    aw_done;
  logic                    w_done;
  logic                    unused_resp;

  // Only resp[1] separates OKAY/EXOKAY from SLVERR/DECERR.
  assign unused_resp = b_resp_i[0] ^ r_resp_i[0];

  assign mem_gnt_o = mem_req_i && (state == IDLE);
  assign b_ready_o = (state == WAIT_B);
  assign r_ready_o = (state == WAIT_R);
  assign aw_addr_o = addr_q;
  assign ar_addr_o = addr_q;
  assign w_data_o  = wdata_q;
  assign w_strb_o  = be_q;
  assign aw_prot_o = AXI_PROT;
  assign ar_prot_o = AXI_PROT;
  assign dbg_state = state;

  assign aw_done = !aw_valid_o || aw_ready_i;
  assign w_done  = !w_valid_o || w_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      aw_valid_o   <= 1'b0;
      w_valid_o    <= 1'b0;
      ar_valid_o   <= 1'b0;
      mem_rvalid_o <= 1'b0;
      mem_rdata_o  <= '0;
      mem_err_o    <= 1'b0;
    end else begin
      mem_rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req_i) begin
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
            be_q    <= mem_be_i;
            if (mem_we_i) begin
              state      <= WRITE;
              aw_valid_o <= 1'b1;
              w_valid_o  <= 1'b1;
            end else begin
              state      <= READ;
              ar_valid_o <= 1'b1;
            end
          end
        end
        WRITE: begin
          // AW and W retire independently; leave once both are done.
          if (aw_valid_o && aw_ready_i) aw_valid_o <= 1'b0;
          if (w_valid_o && w_ready_i)   w_valid_o  <= 1'b0;
          if (aw_done && w_done)        state      <= WAIT_B;
        end
        WAIT_B: begin
          if (b_valid_i) begin
            mem_err_o    <= b_resp_i[1];
            mem_rdata_o  <= '0;
            mem_rvalid_o <= 1'b1;
            state        <= IDLE;
          end
        end
        READ: begin
          if (ar_ready_i) begin
            ar_valid_o <= 1'b0;
            state      <= WAIT_R;
          end
        end
        WAIT_R: begin
          if (r_valid_i) begin
            mem_err_o    <= r_resp_i[1];
            mem_rdata_o  <= r_data_i;
            mem_rvalid_o <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_to_axi_lite.md
Name: mem_to_axi_lite

Overview:
- Bridge from the SoC's simple memory request interface (req/gnt/we/be/rvalid) to a single AXI4-Lite master port.
- It is the initiator-side counterpart of the AXI-to-memory responder. Cores and DMA-style blocks with a native memory port use it to reach the AXI-Lite peripheral space (e.g. the UART) through the crossbar lite path.
- One outstanding transaction at a time; responses return in order by construction.

Parameters:
- ADDR_WIDTH, 64, width of memory and AXI address.
- DATA_WIDTH, 64, width of data; strobe width is DATA_WIDTH/8.
- AXI_PROT, 3'b000, constant value driven on aw_prot_o and ar_prot_o.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- mem_req_i  in  1  memory request
- mem_gnt_o  out  1  request accepted this cycle
- mem_we_i  in  1  1=write, 0=read
- mem_addr_i  in  ADDR_WIDTH  byte address
- mem_wdata_i  in  DATA_WIDTH  write data
- mem_be_i  in  DATA_WIDTH/8  byte enables
- mem_rvalid_o  out  1  response pulse (reads and writes)
- mem_rdata_o  out  DATA_WIDTH  read data, valid with mem_rvalid_o
- mem_err_o  out  1  response error, valid with mem_rvalid_o
- aw_addr_o  out  ADDR_WIDTH;  aw_prot_o  out  3;  aw_valid_o  out  1;  aw_ready_i  in  1
- w_data_o  out  DATA_WIDTH;  w_strb_o  out  DATA_WIDTH/8;  w_valid_o  out  1;  w_ready_i  in  1
- b_resp_i  in  2;  b_valid_i  in  1;  b_ready_o  out  1
- ar_addr_o  out  ADDR_WIDTH;  ar_prot_o  out  3;  ar_valid_o  out  1;  ar_ready_i  in  1
- r_data_i  in  DATA_WIDTH;  r_resp_i  in  2;  r_valid_i  in  1;  r_ready_o  out  1

Behaviour:
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- Reset values: FSM in IDLE; all valid and ready outputs 0; mem_rvalid_o 0, mem_err_o 0, mem_rdata_o 0; address, data and strobe registers 0.
- mem_gnt_o: combinational, equal to mem_req_i AND (state==IDLE).
- On grant, register addr, we, wdata and be. The request side may change the next cycle.
- FSM states: IDLE, WRITE, WAIT_B, READ, WAIT_R.
- IDLE:
  - on grant with we=1, go to WRITE and set aw_valid_o=1, w_valid_o=1 from the next cycle;
  - on grant with we=0, go to READ with ar_valid_o=1.
- WRITE:
  - AW and W handshake independently. Each valid drops the cycle after its own handshake (valid&&ready) and never deasserts before it.
  - When both have completed (including the same cycle), go to WAIT_B.
  - The valids stay stable while waiting: no combinational dependence on ready.
- WAIT_B: b_ready_o=1. On b_valid_i, capture mem_err_o=b_resp_i[1], mem_rdata_o=0, pulse mem_rvalid_o the next cycle, go to IDLE.
- READ: ar_valid_o held until ar_ready_i, then go to WAIT_R with ar_valid_o=0.
- WAIT_R: r_ready_o=1. On r_valid_i, capture mem_rdata_o=r_data_i, mem_err_o=r_resp_i[1], pulse mem_rvalid_o next cycle, go to IDLE.
- mem_rvalid_o: exactly one cycle per granted request. mem_rdata_o and mem_err_o hold their last values until the next response.
- Back-to-back: a new request may be granted in the cycle mem_rvalid_o pulses, since the FSM is already IDLE.
- Minimum latency with a zero-wait slave:
  - grant at cycle 0, AW/W or AR valid at cycle 1;
  - B/R handshake at cycle 2 at the earliest;
  - mem_rvalid_o at cycle 3.
- Error rule: resp OKAY(00) or EXOKAY(01) gives err=0; SLVERR(10) or DECERR(11) gives err=1. Read data is passed through unchanged even on error.
- Address, data and strobe are passed through unchanged, with no alignment or masking. be=0 on a write is still issued on AXI with strb=0.
- A B/R valid in any state other than WAIT_B/WAIT_R is a protocol violation. The bridge ignores it (ready stays 0).
- Reset asserted mid-transaction aborts immediately to reset values. The AXI slave side is reset by the same rst_n.

Test Plan:
- Single write, zero-wait slave: addr=0x1000_0008, wdata=0xDEAD_BEEF_0123_4567, be=0xFF -> gnt at c0; aw_addr=0x1000_0008 and w_data at c1; b at c2; one mem_rvalid_o at c3, err=0, rdata=0.
- Single read, slave with ar_ready delayed 3 cycles and r_data=0xCAFE_F00D_0000_0042 -> ar_valid held stable 4 cycles; mem_rdata_o=0xCAFE_F00D_0000_0042 with a single rvalid pulse.
- Write where W handshakes 2 cycles before AW, then the reverse order, then the same cycle -> each valid drops right after its own handshake; b_ready_o rises only after both complete.
- Error responses: write with b_resp=2'b11 and read with r_resp=2'b10, r_data=0x55 -> mem_err_o=1 both times; rdata=0x55 on the read.
- Back-to-back: 8 alternating read/write requests with req held high -> exactly 8 grants and 8 rvalid pulses in order; no grant outside IDLE.
- Reset asserted in WAIT_R for 1 cycle -> all valid/ready outputs 0 and no rvalid; the next request completes normally.
